// File: rtl/button_counter_pkg.sv
// Shared encodings for the button-driven up/down counter: per-button
// repeat FSM states and the overflow-mode constants.
package button_counter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } btn_state_e;

   localparam logic MODE_WRAP  = 1'b0;
   localparam logic MODE_CLAMP = 1'b1;

endpackage

// File: rtl/button_channel.sv
// One button path: 2-flop synchroniser, run-length debouncer and the
// press / auto-repeat event FSM.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | button released (debounced); next accepted press emits event
// HOLD   | pressed, waiting out the initial repeat delay
// REPEAT | pressed past the delay, emitting an event every repeat period
module button_channel
   import button_counter_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 30,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic clock_divider_out,
   input  logic reset,
   input  logic btn_n,
   output logic pressed,
   output logic press_event
);

   localparam int RUN_W  = $clog2(DEBOUNCE_TICKS) + 1;
   localparam int DLY_W  = $clog2(REPEAT_DELAY) + 1;
   localparam int RATE_W = $clog2(REPEAT_RATE) + 1;

   localparam logic [RUN_W-1:0]  RUN_TC    = RUN_W'(DEBOUNCE_TICKS - 1);
   localparam logic [DLY_W-1:0]  DLY_LOAD  = (REPEAT_DELAY > 0) ? DLY_W'(REPEAT_DELAY - 1) : '0;
   localparam logic [RATE_W-1:0] RATE_LOAD = RATE_W'(REPEAT_RATE - 1);

   logic sync_q1;
   logic sync_q2;
   logic level_pressed;

   always_ff @(posedge clock_divider_out or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
      end
   end

   assign level_pressed = ~sync_q2;

   logic             deb_q;
   logic [RUN_W-1:0] run_q;

   // run_q counts consecutive samples that disagree with the accepted level
   always_ff @(posedge clock_divider_out or posedge reset) begin
      if (reset) begin
         deb_q <= 1'b0;
         run_q <= '0;
      end else if (level_pressed != deb_q) begin
         if (run_q == RUN_TC) begin
            deb_q <= level_pressed;
            run_q <= '0;
         end else begin
            run_q <= run_q + 1'b1;
         end
      end else begin
         run_q <= '0;
      end
   end

   btn_state_e        state_q, state_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic              ev_q, ev_d;

   always_ff @(posedge clock_divider_out or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dly_q   <= '0;
         rate_q  <= '0;
         ev_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         rate_q  <= rate_d;
         ev_q    <= ev_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      rate_d  = rate_q;
      ev_d    = 1'b0;
      if (!deb_q) begin
         state_d = IDLE;
         dly_d   = '0;
         rate_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = HOLD;
               ev_d    = 1'b1;
               dly_d   = DLY_LOAD;
            end
            HOLD: begin
               // a zero delay parks here until release
               if (REPEAT_DELAY != 0) begin
                  if (dly_q == '0) begin
                     state_d = REPEAT;
                     ev_d    = 1'b1;
                     rate_d  = RATE_LOAD;
                  end else begin
                     dly_d = dly_q - 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (rate_q == '0) begin
                  ev_d   = 1'b1;
                  rate_d = RATE_LOAD;
               end else begin
                  rate_d = rate_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign pressed     = deb_q;
   assign press_event = ev_q;

endmodule

// File: rtl/button_updown_counter.sv
// Up/down/clear counter driven by three debounced, auto-repeating buttons,
// with wrap or clamp overflow handling and a one-cycle overflow pulse.
module button_updown_counter
   import button_counter_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int DEBOUNCE_TICKS = 30,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100,
   parameter int SATURATE       = 0
) (
   input  logic             clock_divider_out,
   input  logic             reset,
   input  logic             btn_up_n,
   input  logic             btn_down_n,
   input  logic             btn_clear_n,
   output logic [WIDTH-1:0] count,
   output logic             wrap_pulse,
   output logic [2:0]       pressed
);

   localparam logic             MODE      = (SATURATE != 0) ? MODE_CLAMP : MODE_WRAP;
   localparam logic [WIDTH-1:0] COUNT_MAX = '1;

   logic [2:0] ev;

   button_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_up (
      .clock_divider_out (clock_divider_out),
      .reset             (reset),
      .btn_n             (btn_up_n),
      .pressed           (pressed[0]),
      .press_event       (ev[0])
   );

   button_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_down (
      .clock_divider_out (clock_divider_out),
      .reset             (reset),
      .btn_n             (btn_down_n),
      .pressed           (pressed[1]),
      .press_event       (ev[1])
   );

   // clear never auto-repeats
   button_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (0),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_clear (
      .clock_divider_out (clock_divider_out),
      .reset             (reset),
      .btn_n             (btn_clear_n),
      .pressed           (pressed[2]),
      .press_event       (ev[2])
   );

   logic [WIDTH-1:0] count_d;
   logic             wrap_d;

   always_comb begin
      count_d = count;
      wrap_d  = 1'b0;
      if (ev[2]) begin
         count_d = '0;
      end else if (ev[0] && !ev[1]) begin
         if (count == COUNT_MAX) begin
            wrap_d  = 1'b1;
            count_d = (MODE == MODE_CLAMP) ? COUNT_MAX : '0;
         end else begin
            count_d = count + 1'b1;
         end
      end else if (ev[1] && !ev[0]) begin
         if (count == '0) begin
            wrap_d  = 1'b1;
            count_d = (MODE == MODE_CLAMP) ? '0 : COUNT_MAX;
         end else begin
            count_d = count - 1'b1;
         end
      end
   end

   always_ff @(posedge clock_divider_out or posedge reset) begin
      if (reset) begin
         count      <= '0;
         wrap_pulse <= 1'b0;
      end else begin
         count      <= count_d;
         wrap_pulse <= wrap_d;
      end
   end

endmodule

// File: tb/tb_button_updown_counter.sv
// Bench for button_updown_counter: a wrap-mode instance with auto-repeat and a
// clamp-mode instance without, both checked every cycle against a timing model.
module tb_button_updown_counter;

   localparam int W    = 4;
   localparam int DB   = 4;
   localparam int RATE = 5;
   localparam int MAXV = (1 << W) - 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw_n = 3'b111;

   logic [W-1:0] count_w, count_c;
   logic         wrap_w, wrap_c;
   logic [2:0]   pressed_w, pressed_c;

   always #5 clk = ~clk;

   button_updown_counter #(.WIDTH(W), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(10),
                           .REPEAT_RATE(RATE), .SATURATE(0)) dut_w (
      .clock_divider_out (clk),
      .reset             (reset),
      .btn_up_n          (raw_n[0]),
      .btn_down_n        (raw_n[1]),
      .btn_clear_n       (raw_n[2]),
      .count             (count_w),
      .wrap_pulse        (wrap_w),
      .pressed           (pressed_w)
   );

   button_updown_counter #(.WIDTH(W), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(0),
                           .REPEAT_RATE(RATE), .SATURATE(1)) dut_c (
      .clock_divider_out (clk),
      .reset             (reset),
      .btn_up_n          (raw_n[0]),
      .btn_down_n        (raw_n[1]),
      .btn_clear_n       (raw_n[2]),
      .count             (count_c),
      .wrap_pulse        (wrap_c),
      .pressed           (pressed_c)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Model: pipeline of pressed levels, debounced level, time of latest
   // accepted press; events follow from elapsed time since that press.
   int       m_cnt[2];
   bit       m_wrap[2];
   bit [2:0] m_ev[2];
   bit [2:0] m_s1, m_s2, m_deb;
   int       m_run[3];
   int       m_acc[3];
   int       mt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_ev[i] = 3'b000;
         end
         m_s1 = 3'b000; m_s2 = 3'b000; m_deb = 3'b000;
         for (int b = 0; b < 3; b++) begin
            m_run[b] = 0; m_acc[b] = 0;
         end
      end else begin
         mt++;
         for (int i = 0; i < 2; i++) begin
            bit sat;
            sat = (i == 1);
            m_wrap[i] = 0;
            if (m_ev[i][2]) m_cnt[i] = 0;
            else if (m_ev[i][0] && !m_ev[i][1]) begin
               if (m_cnt[i] == MAXV) begin m_wrap[i] = 1; m_cnt[i] = sat ? MAXV : 0; end
               else m_cnt[i] = m_cnt[i] + 1;
            end else if (m_ev[i][1] && !m_ev[i][0]) begin
               if (m_cnt[i] == 0) begin m_wrap[i] = 1; m_cnt[i] = sat ? 0 : MAXV; end
               else m_cnt[i] = m_cnt[i] - 1;
            end
         end
         for (int i = 0; i < 2; i++) begin
            int dly;
            dly = (i == 0) ? 10 : 0;
            for (int b = 0; b < 3; b++) begin
               int a;
               a = mt - m_acc[b];
               m_ev[i][b] = m_deb[b] && (a == 1 ||
                            (b != 2 && dly > 0 && a >= 1 + dly && (a - 1 - dly) % RATE == 0));
            end
         end
         for (int b = 0; b < 3; b++) begin
            if (m_s2[b] != m_deb[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_deb[b] = ~m_deb[b];
                  m_run[b] = 0;
                  if (m_deb[b]) m_acc[b] = mt;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = ~raw_n;
      end
   end

   always @(negedge clk) begin
      chk("count_w",   int'(count_w),   m_cnt[0]);
      chk("wrap_w",    int'(wrap_w),    int'(m_wrap[0]));
      chk("pressed_w", int'(pressed_w), int'(m_deb));
      chk("count_c",   int'(count_c),   m_cnt[1]);
      chk("wrap_c",    int'(wrap_c),    int'(m_wrap[1]));
      chk("pressed_c", int'(pressed_c), int'(m_deb));
   end

   task automatic goto(input int e);
      int g;
      g = 0;
      while (cyc < e) begin
         @(negedge clk);
         g++;
         if (g > 5000) begin
            chk("goto_timeout", cyc, e);
            break;
         end
      end
   endtask

   task automatic press_start(input logic [2:0] mask, output int c);
      c = cyc;
      raw_n = raw_n & ~mask;
   endtask

   task automatic press_end(input logic [2:0] mask, input int c);
      goto(c + 8);
      raw_n = raw_n | mask;
      goto(c + 20);
   endtask

   task automatic press(input logic [2:0] mask);
      int c;
      press_start(mask, c);
      press_end(mask, c);
   endtask

   initial begin
      int c, k, r;
      goto(3);
      chk("rst_count_w", int'(count_w), 0);
      chk("rst_pressed_c", int'(pressed_c), 0);
      chk("rst_wrap_c", int'(wrap_c), 0);
      #1 reset = 1'b0;

      // first press: count changes exactly 7 edges after the first low sample
      press_start(3'b001, c);
      k = c + 1;
      goto(k + 6);
      chk("first_before", int'(count_c), 0);
      chk("first_pressed", int'(pressed_c), 1);
      goto(k + 7);
      chk("first_c", int'(count_c), 1);
      chk("first_w", int'(count_w), 1);
      goto(k + 19);
      raw_n[0] = 1'b1;
      goto(k + 30);
      chk("single_event_c", int'(count_c), 1);
      chk("repeat_w", int'(count_w), 3);
      chk("released", int'(pressed_c), 0);

      // 3-cycle glitch is rejected
      c = cyc;
      raw_n[0] = 1'b0;
      goto(c + 3);
      raw_n[0] = 1'b1;
      goto(c + 15);
      chk("glitch_pressed", int'(pressed_w), 0);
      chk("glitch_count_c", int'(count_c), 1);

      press_start(3'b100, c);
      goto(c + 7);
      chk("clear_before", int'(count_w), 3);
      goto(c + 8);
      chk("clear_w", int'(count_w), 0);
      chk("clear_c", int'(count_c), 0);
      press_end(3'b100, c);

      // long hold: events at +0, +10, +15, ... +35
      press_start(3'b001, c);
      k = c + 1;
      goto(k + 16);
      chk("rep_pre", int'(count_w), 1);
      goto(k + 17);
      chk("rep_first", int'(count_w), 2);
      goto(k + 39);
      raw_n[0] = 1'b1;
      goto(k + 42);
      chk("rep_seven", int'(count_w), 7);
      goto(k + 55);
      chk("rep_final_w", int'(count_w), 7);
      chk("rep_final_c", int'(count_c), 1);

      press(3'b001);
      press(3'b001);
      chk("nine_w", int'(count_w), 9);
      press_start(3'b101, c);
      goto(c + 7);
      chk("upclr_before", int'(count_w), 9);
      goto(c + 8);
      chk("upclr_w", int'(count_w), 0);
      chk("upclr_c", int'(count_c), 0);
      press_end(3'b101, c);
      press(3'b001);
      press_start(3'b011, c);
      goto(c + 7);
      chk("updn_pressed", int'(pressed_w), 3);
      goto(c + 8);
      chk("updn_w", int'(count_w), 1);
      chk("updn_wrap", int'(wrap_w), 0);
      press_end(3'b011, c);

      // overflow at both ends
      press(3'b100);
      press_start(3'b010, c);
      goto(c + 8);
      chk("dn_wrap_count_w", int'(count_w), 15);
      chk("dn_wrap_pulse_w", int'(wrap_w), 1);
      chk("dn_clamp_count_c", int'(count_c), 0);
      chk("dn_clamp_pulse_c", int'(wrap_c), 1);
      goto(c + 9);
      chk("dn_pulse_end_w", int'(wrap_w), 0);
      chk("dn_pulse_end_c", int'(wrap_c), 0);
      press_end(3'b010, c);
      for (int i = 0; i < 15; i++) press(3'b001);
      chk("fill_c", int'(count_c), 15);
      chk("fill_w", int'(count_w), 14);
      press_start(3'b001, c);
      goto(c + 8);
      chk("up_clamp_c", int'(count_c), 15);
      chk("up_clamp_pulse_c", int'(wrap_c), 1);
      chk("up_noover_w", int'(wrap_w), 0);
      goto(c + 9);
      chk("up_clamp_pulse_end", int'(wrap_c), 0);
      press_end(3'b001, c);
      press_start(3'b001, c);
      goto(c + 8);
      chk("up_wrap_w", int'(count_w), 0);
      chk("up_wrap_pulse_w", int'(wrap_w), 1);
      press_end(3'b001, c);

      // reset during auto-repeat
      press(3'b100);
      for (int i = 0; i < 3; i++) press(3'b001);
      press_start(3'b001, c);
      goto(c + 20);
      chk("prereset_w", int'(count_w), 5);
      #1 reset = 1'b1;
      goto(c + 21);
      chk("inreset_count", int'(count_w), 0);
      chk("inreset_pressed", int'(pressed_w), 0);
      goto(c + 23);
      #1 reset = 1'b0;
      r = c + 23;
      goto(r + 5);
      chk("requal_not_yet", int'(pressed_w), 0);
      goto(r + 6);
      chk("requal_pressed", int'(pressed_w), 1);
      goto(r + 7);
      chk("requal_no_event", int'(count_w), 0);
      goto(r + 8);
      chk("requal_event_w", int'(count_w), 1);
      chk("requal_event_c", int'(count_c), 1);
      raw_n[0] = 1'b1;
      goto(r + 25);
      chk("final_w", int'(count_w), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
